instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 185 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Turns a symbolic instruction request (op, rd, rs1, rs2, imm) into an RV32I
//   machine word for the subset add/sub/and/or/lw/addi/sw/beq/bne. It then
//   writes the words to consecutive instruction-memory addresses through a
//   write port whose request is held until it is acknowledged.
//
// Parameters
//   BASE_ADDR  byte address of the first instruction written
//   DEPTH      maximum number of instructions (power of two, >= 2)
//
// Ports
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   in_valid/in_ready  request handshake
//   in_op              0 add, 1 sub, 2 and, 3 or, 4 lw, 5 addi, 6 sw,
//                      7 beq, 8 bne, 9..15 illegal
//   in_rd/rs1/rs2      register fields, passed through unmasked
//   in_imm             13-bit signed immediate
//   in_last            marks the final instruction of the program
//   mem_we/addr/wdata  write request, held stable until mem_ready
//   mem_ready          memory accepts the write this cycle
//   count              number of instructions written
//   done               program complete (sticky until reset)
//   err, err_code      sticky error: 01 illegal op, 10 bad immediate,
//                      11 overflow
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64,
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [12:0]   in_imm,
  input  logic          in_last,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  typedef enum logic [1:0] {ACCEPT, WRITE, DONE, ERROR} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_LW = 4'd4,
    OP_ADDI = 4'd5, OP_SW = 4'd6, OP_BEQ = 4'd7, OP_BNE = 4'd8
  } op_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ERR_OP  = 2'b01;
  localparam logic [1:0] ERR_IMM = 2'b10;
  localparam logic [1:0] ERR_OVF = 2'b11;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CW-1:0]   count_q, count_d;
  logic            last_q, last_d;
  logic [1:0]      code_q, code_d;

  logic [31:0]     word;
  logic            illegal_op;
  logic            bad_imm;

  // Encoder and legality checks, purely combinational on the request inputs.
  // NOTE: every signal written in always_comb gets a default first; without it
  // a path that skips the assignment infers a latch.
  always_comb begin
    word       = '0;
    illegal_op = 1'b0;
    bad_imm    = 1'b0;
    case (in_op)
      OP_ADD:  word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
      OP_SUB:  word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
      OP_AND:  word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
      OP_OR:   word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
      OP_LW: begin
        // 12-bit immediates must be a sign-extension of bit 11.
        bad_imm = in_imm[12] ^ in_imm[11];
        word    = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
      end
      OP_ADDI: begin
        bad_imm = in_imm[12] ^ in_imm[11];
        word    = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_OPIMM};
      end
      OP_SW: begin
        bad_imm = in_imm[12] ^ in_imm[11];
        word    = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
      end
      OP_BEQ, OP_BNE: begin
        // Branch offsets are in bytes but must be halfword aligned.
        bad_imm = in_imm[0];
        word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                   (in_op == OP_BNE) ? 3'b001 : 3'b000,
                   in_imm[4:1], in_imm[11], OPC_BRANCH};
      end
      default: illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    last_d  = last_q;
    code_d  = code_q;
    case (state_q)
      ACCEPT: begin
        if (in_valid) begin
          if (illegal_op || bad_imm) begin
            state_d = ERROR;
            code_d  = illegal_op ? ERR_OP : ERR_IMM;
          end else begin
            wdata_d = word;
            last_d  = in_last;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (mem_ready) begin
          addr_d  = addr_q + 32'd4;
          count_d = count_q + CW'(1);
          if (last_q) begin
            state_d = DONE;
          end else if (count_d == DEPTH_C) begin
            state_d = ERROR;
            code_d  = ERR_OVF;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      default: ; // DONE and ERROR hold everything until reset
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      last_q  <= last_d;
      code_q  <= code_d;
    end
  end

  assign in_ready  = (state_q == ACCEPT);
  assign mem_we    = (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERROR);
  assign err_code  = code_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed test of instr_encoder. Stimulus pushes the expected {addr, word}
//   of every write into a queue; a monitor on the falling edge pops and
//   compares whenever the DUT completes a write (mem_we && mem_ready).
//   A second instance with DEPTH=4 exercises the overflow path.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [12:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        mem_ready = 1'b0;

  logic        in_ready, mem_we, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [6:0]  count;
  logic [1:0]  err_code;

  logic        in_ready4, mem_we4, done4, err4;
  logic [31:0] mem_addr4, mem_wdata4;
  logic [2:0]  count4;
  logic [1:0]  err_code4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q [$];
  logic [63:0] exp_q4 [$];
  logic [31:0] exp_addr;
  int          exp_count;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_a), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .count(count),
    .done(done), .err(err), .err_code(err_code)
  );

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_b), .in_ready(in_ready4),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .mem_ready(mem_ready), .count(count4),
    .done(done4), .err(err4), .err_code(err_code4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitors: compare every completed write against the queue head.
  initial forever begin
    @(negedge clk);
    if (rst_n && mem_we && mem_ready) begin
      if (exp_q.size() == 0) check("wr_unexpected", {31'b0, mem_we}, 32'd0);
      else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && mem_we4 && mem_ready) begin
      if (exp_q4.size() == 0) check("wr4_unexpected", {31'b0, mem_we4}, 32'd0);
      else begin
        logic [63:0] e;
        e = exp_q4.pop_front();
        check("wr4_addr", mem_addr4, e[63:32]);
        check("wr4_data", mem_wdata4, e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    check("queue_drained", exp_q.size(), 0);
    check("queue4_drained", exp_q4.size(), 0);
    exp_q.delete();
    exp_q4.delete();
    rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; mem_ready = 1'b0; in_last = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_we", {31'b0, mem_we}, 0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_count", {25'b0, count}, 0);
    check("rst_flags", {28'b0, done, err, err_code}, 0);
    check("rst_ready", {31'b0, in_ready}, 1);
    rst_n = 1'b1;
    exp_addr = 32'h0;
    exp_count = 0;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    check("ready_wait", {31'b0, in_ready}, 1);
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [12:0] imm, input logic last);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
  endtask

  // Issue a legal request, stall the memory for `stall` cycles, complete it.
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm, input logic last,
                      input int stall, input logic [31:0] exp_word);
    wait_ready();
    drive(op, rd, rs1, rs2, imm, last);
    valid_a = 1'b1;
    mem_ready = 1'b0;
    exp_q.push_back({exp_addr, exp_word});
    @(posedge clk); #1;
    valid_a = 1'b0;
    in_last = 1'b0;
    check("we_after_accept", {31'b0, mem_we}, 1);
    check("ready_low_in_write", {31'b0, in_ready}, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_we", {31'b0, mem_we}, 1);
      check("stall_addr", mem_addr, exp_addr);
      check("stall_data", mem_wdata, exp_word);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    exp_addr += 32'd4;
    exp_count++;
    check("we_drop", {31'b0, mem_we}, 0);
    check("count", {25'b0, count}, exp_count);
    check("addr_next", mem_addr, exp_addr);
  endtask

  // Issue an illegal request and confirm the sticky error with no write.
  task automatic send_bad(input logic [3:0] op, input logic [12:0] imm, input logic [1:0] code);
    wait_ready();
    drive(op, 5'd1, 5'd2, 5'd3, imm, 1'b0);
    valid_a = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("bad_err", {31'b0, err}, 1);
    check("bad_code", {30'b0, err_code}, {30'b0, code});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bad_ready", {31'b0, in_ready}, 0);
      check("bad_we", {31'b0, mem_we}, 0);
    end
    check("bad_count", {25'b0, count}, 0);
    check("bad_addr", mem_addr, 32'h0);
    valid_a = 1'b0;
    mem_ready = 1'b0;
  endtask

  logic [31:0] depth4_words [4] = '{32'h0000_0093, 32'h0010_0093, 32'h0020_0093, 32'h0030_0093};

  initial begin
    // 1: single add
    do_reset();
    send(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 0, 32'h0020_81B3);

    // 2: sub, then lw (last) with 3-cycle stalls
    do_reset();
    send(4'd1, 5'd5, 5'd6, 5'd7, 13'd0, 1'b0, 3, 32'h4073_02B3);
    send(4'd4, 5'd4, 5'd2, 5'd0, 13'h1FFC, 1'b1, 3, 32'hFFC1_2203);
    check("t2_done", {31'b0, done}, 1);
    check("t2_count", {25'b0, count}, 2);
    check("t2_ready", {31'b0, in_ready}, 0);

    // 3: sw, beq, bne (last)
    do_reset();
    send(4'd6, 5'd0, 5'd2, 5'd5, 13'd8, 1'b0, 0, 32'h0051_2423);
    send(4'd7, 5'd0, 5'd1, 5'd2, 13'd8, 1'b0, 1, 32'h0020_8463);
    send(4'd8, 5'd0, 5'd1, 5'd0, 13'h1FFC, 1'b1, 0, 32'hFE00_9EE3);
    check("t3_done", {31'b0, done}, 1);
    check("t3_err", {31'b0, err}, 0);

    // 4: illegal op, addi +2048, misaligned beq
    do_reset();
    send_bad(4'd12, 13'd0, 2'b01);
    do_reset();
    send_bad(4'd5, 13'h0800, 2'b10);
    do_reset();
    send_bad(4'd7, 13'd3, 2'b10);

    // 5: DEPTH=4 overflow
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int guard = 0;
      while (!in_ready4 && guard < 20) begin @(posedge clk); #1; guard++; end
      check("t5_ready", {31'b0, in_ready4}, 1);
      drive(4'd5, 5'd1, 5'd0, 5'd0, 13'(i), 1'b0);
      valid_b = 1'b1;
      exp_q4.push_back({32'(i * 4), depth4_words[i]});
      @(posedge clk); #1;
      valid_b = 1'b0;
      @(posedge clk); #1;
    end
    check("t5_err", {31'b0, err4}, 1);
    check("t5_code", {30'b0, err_code4}, 3);
    check("t5_count", {29'b0, count4}, 4);
    check("t5_addr", mem_addr4, 32'h10);
    valid_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t5_ignored_we", {31'b0, mem_we4}, 0);
      check("t5_ignored_count", {29'b0, count4}, 4);
    end
    valid_b = 1'b0;
    mem_ready = 1'b0;

    // 6: reset during a stalled write aborts it
    do_reset();
    wait_ready();
    drive(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
    valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    check("t6_we_pending", {31'b0, mem_we}, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_we_abort", {31'b0, mem_we}, 0);
    check("t6_addr", mem_addr, 32'h0);
    check("t6_count", {25'b0, count}, 0);
    rst_n = 1'b1;
    exp_addr = 32'h0;
    exp_count = 0;
    send(4'd3, 5'd9, 5'd10, 5'd11, 13'd0, 1'b1, 0, 32'h00B5_64B3);
    check("t6_done", {31'b0, done}, 1);

    check("final_queue", exp_q.size(), 0);
    check("final_queue4", exp_q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
